// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg
// Shared definitions for the load/store unit: FSM state encodings,
// RV32 load/store func3 codes, decoder wmask constants and the
// misalignment predicate used when LSU_MISALIGN_CHECK_EN is defined.
package lsu_ctrl_pkg;

    // One operation at a time walks IDLE -> REQ -> RESP -> DONE -> IDLE
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Load func3 codes
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // Store func3 codes
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Decoder write masks for byte / half / word accesses
    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
    // The load and store codes for half/word coincide, so one check
    // covers both directions.
    function automatic logic is_misaligned(input logic [2:0] func3,
                                           input logic [1:0] byte_off);
        logic half_acc;
        logic word_acc;
        half_acc = (func3 == F3_LH) || (func3 == F3_LHU);
        word_acc = (func3 == F3_LW);
        return (half_acc && byte_off[0]) || (word_acc && (byte_off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ctrl_extend.sv
// load_extend
// Combinational load-data shaper: picks the byte or half addressed by
// byte_off out of a bus word and sign/zero-extends it according to func3.
// Kept separate so a future cache read path can reuse it.
// Ports:
//   func3    - load type (lb/lh/lw/lbu/lhu; other codes yield 0)
//   byte_off - address bits [1:0]
//   word     - aligned data word from the bus
//   result   - extended load value
module load_extend
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        func3,
    input  logic [1:0]        byte_off,
    input  logic [DATA_W-1:0] word,
    output logic [DATA_W-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halves are selected by addr[1] alone, so an odd-offset half
    // (only reachable when misalignment checking is off) reads the
    // half that contains the lower byte lanes.
    always_comb begin
        byte_sel = word[{byte_off, 3'b000} +: 8];
        half_sel = word[{byte_off[1], 4'b0000} +: 16];
        result   = '0;
        case (func3)
            F3_LB:   result = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_LW:   result = word;
            F3_LBU:  result = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LHU:  result = {{(DATA_W-16){1'b0}}, half_sel};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl
// Single-outstanding load/store unit between the decoder/execute stage
// and the data bus. Accepts one operation in IDLE, issues one bus request,
// waits for the response and presents the (extended) result to write-back.
// Optional feature macro: LSU_MISALIGN_CHECK_EN -- when defined, misaligned
// half/word accesses bypass the bus and complete with out_misalign=1.
// Ports:
//   clk, rst                   - clock, async active-high reset
//   in_valid/in_ready          - core-side operation handshake
//   in_wen/func3/wmask/addr/wdata - operation fields from decode/execute
//   req_valid/req_ready        - bus request handshake
//   req_addr/wen/wdata/wstrb   - word-aligned, lane-shifted bus request
//   rsp_valid/rsp_rdata        - bus response (read data or write ack)
//   out_valid/out_ready        - write-back handshake
//   out_rdata/out_misalign     - load result (0 for stores), misalign flag
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_func3,
    input  logic [7:0]        in_wmask,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_wen,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_misalign
);

    lsu_state_e        state_q;
    lsu_state_e        state_d;

    logic              wen_q;
    logic [2:0]        func3_q;
    logic [7:0]        wmask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] ext_result;
    logic              accept;
    logic              accept_misaligned;

    assign accept = (state_q == LSU_IDLE) && in_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    logic misalign_q;

    assign accept_misaligned = is_misaligned(in_func3, in_addr[1:0]);
    assign out_misalign      = (state_q == LSU_DONE) && misalign_q;

    // The misalign flag is captured with the operation and only shown in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= accept_misaligned;
        end
    end
`else
    assign accept_misaligned = 1'b0;
    assign out_misalign      = 1'b0;
`endif

    // Extract and extend the load value straight from the bus word
    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .func3    (func3_q),
        .byte_off (addr_q[1:0]),
        .word     (rsp_rdata),
        .result   (ext_result)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; bus inputs only matter in the state that owns them,
    // so a response arriving alongside the request handshake is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (in_valid)  state_d = accept_misaligned ? LSU_DONE : LSU_REQ;
            LSU_REQ:  if (req_ready) state_d = LSU_RESP;
            LSU_RESP: if (rsp_valid) state_d = LSU_DONE;
            LSU_DONE: if (out_ready) state_d = LSU_IDLE;
            default:                 state_d = LSU_IDLE;
        endcase
    end

    // Operation fields are latched at accept so the request stays stable
    // while the bus stalls; the result register is cleared at accept so
    // stores and misaligned accesses report 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            func3_q <= '0;
            wmask_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                wen_q   <= in_wen;
                func3_q <= in_func3;
                wmask_q <= in_wmask;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                rdata_q <= '0;
            end
            if ((state_q == LSU_RESP) && rsp_valid && !wen_q) begin
                rdata_q <= ext_result;
            end
        end
    end

    // Handshake and bus outputs; request fields are only driven in REQ and
    // the result only in DONE, so everything idles at its reset value
    always_comb begin
        in_ready  = (state_q == LSU_IDLE);
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        req_wstrb = '0;
        out_valid = 1'b0;
        out_rdata = '0;
        if (state_q == LSU_REQ) begin
            req_valid = 1'b1;
            req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            req_wen   = wen_q;
            req_wdata = DATA_W'(wdata_q << {addr_q[1:0], 3'b000});
            req_wstrb = 4'(wmask_q << addr_q[1:0]);
        end
        if (state_q == LSU_DONE) begin
            out_valid = 1'b1;
            out_rdata = rdata_q;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit directly downstream of the instruction decoder in the NPC core. It accepts one memory operation at a time, with the decoder's `valid`, `mem_wen`, `func3` and `wmask` fields plus an execute-computed address and store data. It drives a single-outstanding request/response data bus and returns load data to write-back, sign- or zero-extended and aligned. It is a four-state FSM with valid/ready handshakes on both the core side and the bus side.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, bus/register data width (only 32 supported)

- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decoder `valid` qualified by the pipeline: a load/store is offered
- `in_ready`  out  1  LSU can accept an operation
- `in_wen`  in  1  decoder `mem_wen`: 1 = store, 0 = load
- `in_func3`  in  3  decoder `func3`
- `in_wmask`  in  8  decoder `wmask` (0x01/0x03/0x0F)
- `in_addr`  in  ADDR_W  effective address
- `in_wdata`  in  DATA_W  rs2 value
- `req_valid`  out  1  bus request valid
- `req_ready`  in  1  bus accepts request
- `req_addr`  out  ADDR_W  word-aligned address ({addr[31:2],2'b0})
- `req_wen`  out  1  write request
- `req_wdata`  out  DATA_W  lane-shifted store data
- `req_wstrb`  out  4  byte strobe
- `rsp_valid`  in  1  bus response (read data or write ack)
- `rsp_rdata`  in  DATA_W  read data word
- `out_valid`  out  1  operation complete
- `out_ready`  in  1  write-back consumes result
- `out_rdata`  out  DATA_W  extended load result (0 for stores)
- `out_misalign`  out  1  misaligned-access flag

## Operation
- States: IDLE → REQ → RESP → DONE → IDLE.
- IDLE: `in_ready`=1. On `in_valid`, register wen, func3, wmask, addr, wdata and go to REQ.
- REQ: `req_valid`=1, outputs driven from the registered fields and held stable until `req_ready`. Then go to RESP.
- RESP: wait for `rsp_valid`. Loads capture `rsp_rdata`. Then go to DONE.
- DONE: `out_valid`=1, result held until `out_ready`. Then go to IDLE.
- Store shaping: `req_wstrb` = (wmask[3:0] << addr[1:0])[3:0]; `req_wdata` = wdata << (8·addr[1:0]), truncated to 32 bits.
- Load extension, using byte offset addr[1:0]:
  - func3 0 lb: sext byte
  - func3 1 lh: sext half at addr[1]
  - func3 2 lw: word
  - func3 4 lbu: zext byte
  - func3 5 lhu: zext half
  - func3 3/6/7: 0
- `rsp_valid` outside RESP is ignored.
- `req_ready` outside REQ is ignored.

## Timing
- Reset values: state IDLE, `in_ready`=1, `req_valid`=0, `req_wen`=0, `req_addr`/`req_wdata`/`req_wstrb`=0, `out_valid`=0, `out_rdata`=0, `out_misalign`=0.
- Minimum latency with zero-wait bus: accept at edge 0 → `req_valid` cycle 1 → `rsp_valid` accepted cycle 2 → `out_valid` cycle 3. Four cycles per operation with `out_ready`=1.
- `req_ready` and `rsp_valid` in the same REQ cycle: only the request handshake counts. The response must arrive in RESP.
- No new operation is accepted until the DONE handshake completes; there is no overlap.
- Reset mid-operation: return to IDLE immediately. A late bus response is dropped.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined: an access is misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]≠0. A misaligned access skips REQ/RESP and goes IDLE → DONE. In DONE it drives `out_misalign`=1 and `out_rdata`=0, and issues no bus traffic.
- Macro undefined: `out_misalign` tied 0. All accesses are issued; strobe/data bits shifted past lane 3 are dropped, and loads extract from the shifted word as above.

## Structure
- The shared header holds:
  - state encodings `LSU_IDLE/REQ/RESP/DONE`
  - func3 constants `F3_LB/LH/LW/LBU/LHU/SB/SH/SW`
  - mask constants
- One combinational sub-module, `load_extend` (func3, addr[1:0], word → result), reused by any future cache path.

## Test plan
- lw at 0x80000010, bus returns 0xDEADBEEF, zero-wait → `out_rdata`=0xDEADBEEF on cycle 3, `req_addr`=0x80000010.
- lb at 0x80000003, word 0x80FF_0000 → `out_rdata`=0xFFFFFF80; lbu same → 0x00000080.
- sh at 0x80000002, wdata 0x1234ABCD → `req_wstrb`=0b1100, `req_wdata`=0xABCD0000, `req_wen`=1, `out_rdata`=0.
- `req_ready` held low 5 cycles, then `out_ready` low 3 cycles → request fields stable throughout, exactly one bus request, `out_valid` held, `in_ready`=0 until release.
- Assert `rst` while in RESP, then pulse `rsp_valid` → outputs return to reset values, no `out_valid`.
- With `LSU_MISALIGN_CHECK_EN`, lw at 0x80000001 → no `req_valid`, `out_misalign`=1 on cycle 1, `out_rdata`=0.
